// File: rtl/gpio_padctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_padctrl
// Description : Per-channel control for a bank of bidirectional PDB02DGZ pads.
//               Programmable direction and output data, two-flop input
//               synchronisation, optional debounce filtering, and per-channel
//               edge interrupts with write-1-to-clear status.
//               Optional feature macro: GPIO_PADCTRL_DEBOUNCE_EN
//                 defined   -> debounce counters, din latency 2 + DEB_CYCLES
//                 undefined -> din is a register of the synchroniser output,
//                              din latency 3, DEB_CYCLES unused
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_padctrl #(
  parameter int NCH        = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic           refclk,
  input  logic           reset,
  input  logic [NCH-1:0] pad_c,
  output logic [NCH-1:0] pad_i,
  output logic [NCH-1:0] pad_oen,
  input  logic           wr_en,
  input  logic [1:0]     wr_sel,
  input  logic [NCH-1:0] wr_data,
  input  logic [1:0]     rd_sel,
  output logic [NCH-1:0] rd_data,
  output logic [NCH-1:0] din,
  output logic           irq
);

  // Register map select codes shared by the write and read ports
  localparam logic [1:0] c_sel_dir   = 2'd0;
  localparam logic [1:0] c_sel_dout  = 2'd1;
  localparam logic [1:0] c_sel_irqen = 2'd2;
  localparam logic [1:0] c_sel_irqst = 2'd3;

  // Illegal parameter values stop elaboration rather than building odd hardware
  if (NCH < 1 || NCH > 32 || DEB_CYCLES < 1) begin : g_param_check
    $error("gpio_padctrl: NCH must be 1..32 and DEB_CYCLES must be >= 1");
  end

  // --------------------------------------------------------------------------
  // Programmable registers
  // --------------------------------------------------------------------------
  logic [NCH-1:0] r_dir;
  logic [NCH-1:0] r_dout;
  logic [NCH-1:0] r_irq_en;
  logic [NCH-1:0] r_irq_stat;
  logic [NCH-1:0] r_pad_oen;
  logic [NCH-1:0] r_pad_i;

  logic w_wr_dir;
  logic w_wr_dout;
  logic w_wr_irqen;
  logic w_wr_irqst;

  assign w_wr_dir   = wr_en && (wr_sel == c_sel_dir);
  assign w_wr_dout  = wr_en && (wr_sel == c_sel_dout);
  assign w_wr_irqen = wr_en && (wr_sel == c_sel_irqen);
  assign w_wr_irqst = wr_en && (wr_sel == c_sel_irqst);

  // Direction and output data; the pad-facing copies load in the same edge so
  // the pad pins come straight from flops with no logic in front of the ring.
  always_ff @(posedge refclk) begin
    if (reset) begin
      r_dir     <= '0;
      r_dout    <= '0;
      r_irq_en  <= '0;
      r_pad_oen <= '1;
      r_pad_i   <= '0;
    end else begin
      if (w_wr_dir) begin
        r_dir     <= wr_data;
        r_pad_oen <= ~wr_data;
      end
      if (w_wr_dout) begin
        r_dout  <= wr_data;
        r_pad_i <= wr_data;
      end
      if (w_wr_irqen) begin
        r_irq_en <= wr_data;
      end
    end
  end

  assign pad_oen = r_pad_oen;
  assign pad_i   = r_pad_i;

  // --------------------------------------------------------------------------
  // Input path: two-flop synchroniser into the filter
  // --------------------------------------------------------------------------
  logic [NCH-1:0] r_s1;
  logic [NCH-1:0] r_s2;
  logic [NCH-1:0] r_din;
  logic [NCH-1:0] r_din_q;
  logic [NCH-1:0] w_din_nxt;

  // Bring the asynchronous pad C pins into the refclk domain
  always_ff @(posedge refclk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pad_c;
      r_s2 <= r_s1;
    end
  end

`ifdef GPIO_PADCTRL_DEBOUNCE_EN
  // Counter sized so DEB_CYCLES-1 is always representable, even for DEB_CYCLES=1
  localparam int c_cnt_w = $clog2(DEB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

  for (genvar k = 0; k < NCH; k++) begin : g_deb
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_diff;
    logic               w_expire;

    assign w_diff   = r_s2[k] ^ r_din[k];
    assign w_expire = w_diff && (r_cnt == c_cnt_last);

    // Count consecutive cycles of disagreement; restart on agreement or accept
    always_ff @(posedge refclk) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (!w_diff || w_expire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end

    assign w_din_nxt[k] = w_expire ? r_s2[k] : r_din[k];
  end
`else
  // No filtering: din is simply one more register stage after the synchroniser
  assign w_din_nxt = r_s2;
`endif

  // Filtered value and its one-cycle delay used for edge detection
  always_ff @(posedge refclk) begin
    if (reset) begin
      r_din   <= '0;
      r_din_q <= '0;
    end else begin
      r_din   <= w_din_nxt;
      r_din_q <= r_din;
    end
  end

  assign din = r_din;

  // --------------------------------------------------------------------------
  // Edge detect and interrupt status
  // --------------------------------------------------------------------------
  logic [NCH-1:0] w_edge;
  logic [NCH-1:0] w_set;
  logic [NCH-1:0] w_clr;

  assign w_edge = r_din ^ r_din_q;
  // Only channels currently configured as inputs may flag an edge
  assign w_set  = w_edge & ~r_dir;
  assign w_clr  = w_wr_irqst ? wr_data : '0;

  // Write-1-to-clear status; a new edge in the same cycle overrides the clear
  always_ff @(posedge refclk) begin
    if (reset) begin
      r_irq_stat <= '0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_set;
    end
  end

  assign irq = |(r_irq_stat & r_irq_en);

  // Read-back mux straight from the registers, so a same-cycle write reads old
  always_comb begin
    rd_data = '0;
    case (rd_sel)
      c_sel_dir:   rd_data = r_dir;
      c_sel_dout:  rd_data = r_dout;
      c_sel_irqen: rd_data = r_irq_en;
      c_sel_irqst: rd_data = r_irq_stat;
      default:     rd_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_padctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_padctrl
// Description : Self-checking bench for gpio_padctrl: register table vectors,
//               directed debounce / interrupt / reset sequences, and a random
//               phase compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_padctrl;

  localparam int NCH = 8;
  localparam int DEB = 4;
`ifdef GPIO_PADCTRL_DEBOUNCE_EN
  localparam int LAT    = 2 + DEB;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif

  logic           refclk = 1'b0;
  logic           reset;
  logic [NCH-1:0] pad_c;
  logic [NCH-1:0] pad_i;
  logic [NCH-1:0] pad_oen;
  logic           wr_en;
  logic [1:0]     wr_sel;
  logic [NCH-1:0] wr_data;
  logic [1:0]     rd_sel;
  logic [NCH-1:0] rd_data;
  logic [NCH-1:0] din;
  logic           irq;

  always #5 refclk = ~refclk;

  gpio_padctrl #(.NCH(NCH), .DEB_CYCLES(DEB)) dut (
    .refclk  (refclk),
    .reset   (reset),
    .pad_c   (pad_c),
    .pad_i   (pad_i),
    .pad_oen (pad_oen),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .din     (din),
    .irq     (irq)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  logic [NCH-1:0] m_dir, m_dout, m_en, m_stat, m_oen, m_pi;
  logic [NCH-1:0] m_din, m_din_q, m_s1, m_s2;
  logic [NCH-1:0] m_win[$];   // most recent synchronised samples, oldest first
  logic [NCH-1:0] ext;        // externally driven level on input channels

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] model_rd(input logic [1:0] s);
    case (s)
      2'd0:    return m_dir;
      2'd1:    return m_dout;
      2'd2:    return m_en;
      default: return m_stat;
    endcase
  endfunction

  // One clock edge of the model, using the inputs the DUT sampled at that edge
  task automatic model_tick();
    logic [NCH-1:0] s2_now, ev, nd;
    bit all_diff;
    if (reset) begin
      m_dir = '0; m_dout = '0; m_en = '0; m_stat = '0;
      m_oen = '1; m_pi = '0;
      m_din = '0; m_din_q = '0; m_s1 = '0; m_s2 = '0;
      m_win.delete();
      return;
    end
    s2_now = m_s2;
    ev     = m_din ^ m_din_q;
    m_stat = ((wr_en && wr_sel == 2'd3) ? (m_stat & ~wr_data) : m_stat) | (ev & ~m_dir);
    m_din_q = m_din;
    nd = m_din;
    if (DEB_ON) begin
      // accept a new level once DEB consecutive samples all disagree with din
      m_win.push_back(s2_now);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      if (m_win.size() == DEB) begin
        for (int k = 0; k < NCH; k++) begin
          all_diff = 1'b1;
          foreach (m_win[i]) if (m_win[i][k] == m_din[k]) all_diff = 1'b0;
          if (all_diff) nd[k] = ~m_din[k];
        end
      end
    end else begin
      nd = s2_now;
    end
    m_din = nd;
    m_s2  = m_s1;
    m_s1  = pad_c;
    if (wr_en) begin
      case (wr_sel)
        2'd0: begin m_dir = wr_data; m_oen = ~wr_data; end
        2'd1: begin m_dout = wr_data; m_pi = wr_data; end
        2'd2: m_en = wr_data;
        default: ;
      endcase
    end
  endtask

  // Pads driven by the chip loop back to C; input pads follow ext
  task automatic drive_pads();
    pad_c = (m_pi & ~m_oen) | (ext & m_oen);
  endtask

  task automatic set_ext(input logic [NCH-1:0] v);
    ext = v;
    drive_pads();
  endtask

  task automatic check_all();
    chk("pad_oen", pad_oen, m_oen);
    chk("pad_i", pad_i, m_pi);
    chk("din", din, m_din);
    chk("irq", irq, |(m_stat & m_en));
    chk("rd_data", rd_data, model_rd(rd_sel));
  endtask

  task automatic step();
    @(posedge refclk);
    model_tick();
    #1;
    drive_pads();
    check_all();
  endtask

  task automatic write_reg(input logic [1:0] s, input logic [NCH-1:0] d);
    wr_en = 1'b1; wr_sel = s; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // ---------------- register vector table ----------------
  typedef struct {
    logic           we;
    logic [1:0]     ws;
    logic [NCH-1:0] wd;
    logic [1:0]     rs;
    logic [NCH-1:0] rd_now;    // read in the cycle of the write (old value)
    logic [NCH-1:0] oen_after;
    logic [NCH-1:0] pi_after;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    vt[0] = '{1'b1, 2'd0, 8'h0F, 2'd0, 8'h00, 8'hF0, 8'h00};
    vt[1] = '{1'b1, 2'd1, 8'hA5, 2'd1, 8'h00, 8'hF0, 8'hA5};
    vt[2] = '{1'b0, 2'd0, 8'h00, 2'd0, 8'h0F, 8'hF0, 8'hA5};
    vt[3] = '{1'b0, 2'd0, 8'h00, 2'd1, 8'hA5, 8'hF0, 8'hA5};
    vt[4] = '{1'b1, 2'd2, 8'h20, 2'd2, 8'h00, 8'hF0, 8'hA5};
    vt[5] = '{1'b0, 2'd0, 8'h00, 2'd2, 8'h20, 8'hF0, 8'hA5};
    vt[6] = '{1'b1, 2'd3, 8'hFF, 2'd3, 8'h00, 8'hF0, 8'hA5};
    vt[7] = '{1'b0, 2'd0, 8'h00, 2'd0, 8'h0F, 8'hF0, 8'hA5};

    reset = 1'b1; wr_en = 1'b0; wr_sel = 2'd0; wr_data = '0; rd_sel = 2'd0;
    ext = '0; pad_c = '0;

    // ---- reset ----
    step();
    step();
    reset = 1'b0;
    chk("rst_pad_oen", pad_oen, 8'hFF);
    chk("rst_pad_i", pad_i, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_din", din, 8'h00);
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      chk("rst_rd_data", rd_data, 8'h00);
    end

    // ---- register table ----
    for (int i = 0; i < 8; i++) begin
      wr_en = vt[i].we; wr_sel = vt[i].ws; wr_data = vt[i].wd; rd_sel = vt[i].rs;
      #1;
      chk("tbl_rd_same_cycle", rd_data, vt[i].rd_now);
      step();
      wr_en = 1'b0;
      chk("tbl_pad_oen", pad_oen, vt[i].oen_after);
      chk("tbl_pad_i", pad_i, vt[i].pi_after);
    end

    // ---- loopback: driven channels appear on din ----
    rd_sel = 2'd3;
    for (int i = 0; i < LAT + 2; i++) step();
    chk("loopback_din", din[3:0], 4'h5);
    chk("loopback_no_stat", rd_data, 8'h00);

`ifdef GPIO_PADCTRL_DEBOUNCE_EN
    // ---- glitch shorter than the filter window ----
    set_ext(8'h20);
    for (int i = 0; i < 3; i++) step();
    set_ext(8'h00);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch_din5", din[5], 1'b0);
      chk("glitch_stat", rd_data, 8'h00);
    end
`endif

    // ---- held high: exact latency, then interrupt one cycle later ----
    set_ext(8'h20);
    for (int i = 1; i <= LAT + 2; i++) begin
      step();
      chk("held_din5", din[5], (i >= LAT) ? 1'b1 : 1'b0);
      chk("held_irq", irq, (i >= LAT + 1) ? 1'b1 : 1'b0);
    end
    chk("held_stat", rd_data, 8'h20);

    // ---- W1C clears irq on the next cycle ----
    write_reg(2'd3, 8'h20);
    chk("w1c_irq", irq, 1'b0);
    chk("w1c_stat", rd_data, 8'h00);

    // ---- falling edge sets the flag again ----
    set_ext(8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (din[5] == 1'b0) seen = 1'b1;
    end
    chk("fall_din5_seen", seen, 1'b1);
    step();
    chk("fall_stat", rd_data, 8'h20);
    chk("fall_irq", irq, 1'b1);
    write_reg(2'd3, 8'h20);
    chk("fall_clr_irq", irq, 1'b0);

    // ---- set and clear collide on the edge cycle: set wins ----
    set_ext(8'h20);
    for (int i = 0; i < LAT; i++) step();
    chk("coll_din5", din[5], 1'b1);
    write_reg(2'd3, 8'h20);
    chk("coll_stat5", rd_data[5], 1'b1);
    chk("coll_irq", irq, 1'b1);
    write_reg(2'd3, 8'hFF);
    chk("coll_cleared", rd_data, 8'h00);

    // ---- reset in the middle of a debounce ----
    write_reg(2'd0, 8'h00);
    set_ext(8'h24);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_din2", din[2], 1'b0);
    chk("rstmid_stat", rd_data, 8'h00);
    for (int i = 1; i <= LAT + 1; i++) begin
      step();
      chk("rstmid_din2_lat", din[2], (i >= LAT) ? 1'b1 : 1'b0);
    end

    // ---- randomised traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      logic [NCH-1:0] nx;
      nx = ext;
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 7) == 0) nx[k] = ~nx[k];
      set_ext(nx);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_sel  = 2'($urandom_range(0, 3));
      wr_data = NCH'($urandom);
      rd_sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
